// File: rtl/eth_pkg.sv
// eth_pkg: shared MDIO clause-22 definitions (frame field codes, field lengths, FSM states).
// Latency: n/a, definitions only.
// Backpressure: n/a.
package eth_pkg;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  localparam int MDIO_PRE_LEN   = 32;
  localparam int MDIO_HDR_LEN   = 46;
  localparam int MDIO_TA_LEN    = 2;
  localparam int MDIO_DATA_LEN  = 16;
  localparam int MDIO_FRAME_LEN = MDIO_HDR_LEN + MDIO_TA_LEN + MDIO_DATA_LEN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_DONE
  } mdio_state_e;

  // Full 64-bit wire image, MSB first. For reads the TA/DATA part is never driven.
  function automatic logic [MDIO_FRAME_LEN-1:0] mdio_frame(
    input logic        wr,
    input logic [4:0]  phy,
    input logic [4:0]  regad,
    input logic [15:0] data
  );
    return {{MDIO_PRE_LEN{1'b1}}, MDIO_ST, (wr ? MDIO_OP_WRITE : MDIO_OP_READ),
            phy, regad, MDIO_TA_WRITE, data};
  endfunction

endpackage

// File: rtl/eth_mdc_gen.sv
// eth_mdc_gen: MDC divider; MDC rises CLK_DIV cycles after each bit launch, falls CLK_DIV later.
// Latency: first rise CLK_DIV cycles after clr_i; ticks are combinational, mdc_o is registered.
// Backpressure: none; runs while run_i is high, held low/cleared otherwise.
// Ports: clk_mac/rst_n; clr_i sync clear; run_i enable; mdc_en_i lets MDC go high;
//        mdc_o; mdc_rise_tick_o/mdc_fall_tick_o mark the cycle whose edge moves MDC.
module eth_mdc_gen #(
  parameter int CLK_DIV = 12
) (
  input  logic clk_mac,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  input  logic mdc_en_i,
  output logic mdc_o,
  output logic mdc_rise_tick_o,
  output logic mdc_fall_tick_o
);

  localparam int            CW      = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;

  assign mdc_rise_tick_o = run_i && !clr_i && (cnt_q == RISE_AT);
  assign mdc_fall_tick_o = run_i && !clr_i && (cnt_q == FALL_AT);
  assign mdc_o           = mdc_q;

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (clr_i || !run_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else begin
      cnt_d = (cnt_q == FALL_AT) ? '0 : cnt_q + CW'(1);
      // mdc_en_i masks the high phase so MDC stays low during the DONE period
      if (mdc_rise_tick_o && mdc_en_i) begin
        mdc_d = 1'b1;
      end else if (mdc_fall_tick_o) begin
        mdc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/eth_mdio_master.sv
// eth_mdio_master: clause-22 MDIO/SMI master, one register read or write per valid/ready handshake.
// Latency: ready reasserts 130*CLK_DIV cycles after accept (64 MDC bit periods plus one DONE period).
// Backpressure: ready stays low for the whole frame; valid and command fields are ignored until then.
// Ports: clk_mac, rst_n (async active-low); valid/ready/write/write_value/phyaddr/register command;
//        read_value/read_err result of the last read; eth_mdc/eth_mdio PHY management pins.
// Optional: define ETH_MDIO_TA_CHECK_EN to flag reads where no PHY pulled MDIO low in the second TA bit.
module eth_mdio_master
  import eth_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic        clk_mac,
  input  logic        rst_n,
  input  logic        valid,
  output logic        ready,
  input  logic        write,
  input  logic [15:0] write_value,
  input  logic [4:0]  phyaddr,
  input  logic [4:0]  register,
  output logic [15:0] read_value,
  output logic        read_err,
  output logic        eth_mdc,
  inout  wire         eth_mdio
);

  localparam logic [5:0] HDR_LAST  = 6'(MDIO_HDR_LEN - 1);
  localparam logic [5:0] TA_LAST   = 6'(MDIO_TA_LEN - 1);
  localparam logic [5:0] DATA_LAST = 6'(MDIO_DATA_LEN - 1);

  mdio_state_e state_q;
  logic        ready_q;
  logic        wr_q;
  logic        oe_q;
  logic        out_q;
  logic [5:0]  bit_cnt_q;
  logic [62:0] tx_q;       // bits still to be launched after out_q
  logic [15:0] rx_q;
  logic [15:0] read_value_q;
  logic        accept;
  logic        rise_tick;
  logic        fall_tick;

  assign accept     = valid && ready_q;
  assign ready      = ready_q;
  assign read_value = read_value_q;
  assign eth_mdio   = oe_q ? out_q : 1'bz;

  eth_mdc_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_mdc_gen (
    .clk_mac         (clk_mac),
    .rst_n           (rst_n),
    .clr_i           (accept),
    .run_i           (state_q != ST_IDLE),
    .mdc_en_i        (state_q != ST_DONE),
    .mdc_o           (eth_mdc),
    .mdc_rise_tick_o (rise_tick),
    .mdc_fall_tick_o (fall_tick)
  );

`ifdef ETH_MDIO_TA_CHECK_EN
  logic ta_err_q;
  logic read_err_q;
  assign read_err = read_err_q;
`else
  assign read_err = 1'b0;
`endif

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      wr_q         <= 1'b0;
      oe_q         <= 1'b0;
      out_q        <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      read_value_q <= '0;
`ifdef ETH_MDIO_TA_CHECK_EN
      ta_err_q     <= 1'b0;
      read_err_q   <= 1'b0;
`endif
    end else begin
      // every falling MDC edge inside the frame launches the next wire bit
      if (fall_tick && (state_q == ST_HDR || state_q == ST_TA || state_q == ST_DATA)) begin
        out_q <= tx_q[62];
        tx_q  <= {tx_q[61:0], 1'b0};
      end
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q         <= 1'b0;
            state_q         <= ST_HDR;
            wr_q            <= write;
            oe_q            <= 1'b1;
            {out_q, tx_q}   <= mdio_frame(write, phyaddr, register, write_value);
            bit_cnt_q       <= '0;
          end
        end
        ST_HDR: begin
          if (fall_tick) begin
            if (bit_cnt_q == HDR_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_TA;
              if (!wr_q) oe_q <= 1'b0;  // PHY owns the line from TA onward
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        ST_TA: begin
`ifdef ETH_MDIO_TA_CHECK_EN
          // a present PHY pulls the second TA bit low; 1 means nobody answered
          if (rise_tick && !wr_q && bit_cnt_q == TA_LAST) ta_err_q <= eth_mdio;
`endif
          if (fall_tick) begin
            if (bit_cnt_q == TA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        ST_DATA: begin
          if (rise_tick && !wr_q) rx_q <= {rx_q[14:0], eth_mdio};
          if (fall_tick) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DONE;
              oe_q      <= 1'b0;
              if (!wr_q) begin
                read_value_q <= rx_q;
`ifdef ETH_MDIO_TA_CHECK_EN
                read_err_q   <= ta_err_q;
`endif
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        ST_DONE: begin
          if (fall_tick) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
